// File: rtl/pcpu_clint.sv
// pcpu_clint: machine timer and edge-triggered external interrupt controller on the pCPU word bus.
// Define PCPU_CLINT_EXT_IRQ_EN to include the external lines and registers 4-6.
module pcpu_clint #(
    parameter int PRESCALE = 1,
    parameter int NEXT     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     a,
    input  logic [31:0]     d,
    input  logic            we,
    input  logic            rd,
    output logic [31:0]     spo,
    output logic            ready,
    input  logic [NEXT-1:0] irq_in,
    output logic            eip,
    output logic            eip_istimer,
    input  logic            eip_reply
);
    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [2:0]      idx;
    logic [31:0]     dv;
    logic [63:0]     mtime, mtimecmp;
    logic [31:0]     shadow, pcnt, claim;
    logic            timer_pend;
    logic [NEXT-1:0] enable, pending, act;
    logic [31:0]     regs [8];
    logic            unused_bus;

    assign idx         = a[4:2];
    assign dv          = swap(d);
    assign unused_bus  = ^{a[31:5], a[1:0]};
    assign eip_istimer = timer_pend;
    assign act         = pending & enable;

    always_comb begin
        regs[0] = mtime[31:0];
        regs[1] = shadow;
        regs[2] = mtimecmp[31:0];
        regs[3] = mtimecmp[63:32];
        regs[4] = 32'(enable);
        regs[5] = 32'(pending);
        regs[6] = claim;
        regs[7] = '0;
    end

    // a write to either mtime half wins over the increment and restarts the prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            ready      <= 1'b0;
            spo        <= '0;
            mtime      <= '0;
            shadow     <= '0;
            mtimecmp   <= '1;
            pcnt       <= '0;
            timer_pend <= 1'b0;
        end else begin
            ready      <= rd | we;
            spo        <= (rd && !we) ? swap(regs[idx]) : '0;
            timer_pend <= mtime >= mtimecmp;
            if (rd && !we && idx == 3'd0) shadow <= mtime[63:32];
            if (we && idx == 3'd2) mtimecmp[31:0] <= dv;
            if (we && idx == 3'd3) mtimecmp[63:32] <= dv;
            if (we && idx == 3'd0) begin
                mtime[31:0] <= dv;
                pcnt        <= '0;
            end else if (we && idx == 3'd1) begin
                mtime[63:32] <= dv;
                pcnt         <= '0;
            end else if (pcnt == 32'(PRESCALE - 1)) begin
                mtime <= mtime + 64'd1;
                pcnt  <= '0;
            end else begin
                pcnt <= pcnt + 32'd1;
            end
        end
    end

`ifdef PCPU_CLINT_EXT_IRQ_EN
    logic [NEXT-1:0] irq_prev, clr;

    always_comb begin
        claim = '0;
        for (int i = NEXT - 1; i >= 0; i--) if (act[i]) claim = 32'(i + 1);
    end

    // a reply to an external interrupt clears the lowest claimable bit
    assign clr = ((we && idx == 3'd5) ? dv[NEXT-1:0] : '0)
               | ((eip_reply && !timer_pend) ? (act & (~act + NEXT'(1))) : '0);
    assign eip = timer_pend | (|act);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            enable   <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_in;
            if (we && idx == 3'd4) enable <= dv[NEXT-1:0];
            pending <= (pending & ~clr) | (irq_in & ~irq_prev);
        end
    end
`else
    logic unused_ext;

    assign enable     = '0;
    assign pending    = '0;
    assign claim      = '0;
    assign eip        = timer_pend;
    assign unused_ext = ^{irq_in, eip_reply, act};
`endif
endmodule

// File: tb/tb_pcpu_clint.sv
// tb_pcpu_clint: table-driven, directed and randomized checks of pcpu_clint against a behavioural model.
module tb_pcpu_clint;
    localparam int PRESCALE = 1;
    localparam int NEXT     = 4;

    logic            clk = 1'b0, rst = 1'b1;
    logic [31:0]     a = '0, d = '0, spo;
    logic            we = 1'b0, rd = 1'b0, ready, eip, eip_istimer, eip_reply = 1'b0;
    logic [NEXT-1:0] irq_in = '0;
    int              tests = 0, fails = 0, cyc = 0;

    pcpu_clint #(.PRESCALE(PRESCALE), .NEXT(NEXT)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
        .irq_in(irq_in), .eip(eip), .eip_istimer(eip_istimer), .eip_reply(eip_reply)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] sw(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural model: mtime is a base value plus elapsed cycles
    logic [63:0]     m_base, m_cmp;
    int              m_cnt;
    logic [31:0]     m_shadow, e_spo;
    logic            m_tp, e_ready, e_rd, e_eip, e_ist;
    logic [NEXT-1:0] m_en, m_pend, m_prev;

    function automatic int first_claim(input logic [NEXT-1:0] v);
        for (int i = 0; i < NEXT; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_base = '0; m_cnt = 0; m_cmp = '1; m_shadow = '0; m_tp = 1'b0;
        m_en = '0; m_pend = '0; m_prev = '0;
    endtask

    task automatic model_step();
        logic [63:0] cur;
        logic [31:0] v, rv;
        logic [2:0] ix;
        logic tp_new;
        int cl;
        ix = a[4:2];
        v = sw(d);
        cur = m_base + 64'(m_cnt / PRESCALE);
        cl = first_claim(m_pend & m_en);
        case (ix)
            3'd0: rv = cur[31:0];
            3'd1: rv = m_shadow;
            3'd2: rv = m_cmp[31:0];
            3'd3: rv = m_cmp[63:32];
            3'd4: rv = 32'(m_en);
            3'd5: rv = 32'(m_pend);
            3'd6: rv = 32'(cl);
            default: rv = '0;
        endcase
        e_ready = rd | we;
        e_rd = rd & ~we;
        e_spo = sw(rv);
        tp_new = cur >= m_cmp;
        if (e_rd && ix == 3'd0) m_shadow = cur[63:32];
`ifdef PCPU_CLINT_EXT_IRQ_EN
        begin
            logic [NEXT-1:0] clr;
            clr = (we && ix == 3'd5) ? v[NEXT-1:0] : '0;
            if (eip_reply && !m_tp && cl != 0) clr[cl-1] = 1'b1;
            m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
            if (we && ix == 3'd4) m_en = v[NEXT-1:0];
        end
`endif
        m_prev = irq_in;
        if (we && ix == 3'd2) m_cmp[31:0] = v;
        if (we && ix == 3'd3) m_cmp[63:32] = v;
        if (we && ix == 3'd0) begin
            m_base = {cur[63:32], v}; m_cnt = 0;
        end else if (we && ix == 3'd1) begin
            m_base = {v, cur[31:0]}; m_cnt = 0;
        end else m_cnt++;
        m_tp = tp_new;
        e_ist = m_tp;
        e_eip = m_tp | (|(m_pend & m_en));
    endtask

    task automatic do_reset();
        rst = 1'b1; rd = 1'b0; we = 1'b0; irq_in = '0; eip_reply = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic bus(input logic r, input logic w, input logic [2:0] ix, input logic [31:0] dw);
        rd = r; we = w; a = {27'd0, ix, 2'd0}; d = dw;
        @(negedge clk);
        rd = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] ix, input logic [31:0] v);
        bus(1'b0, 1'b1, ix, sw(v));
    endtask

    task automatic rd_chk(input string name, input logic [2:0] ix, input logic [31:0] exp_cpu);
        bus(1'b1, 1'b0, ix, '0);
        chk({name, "_ready"}, ready, 1);
        chk(name, spo, sw(exp_cpu));
    endtask

    typedef struct {
        logic        r, w;
        logic [2:0]  idx;
        logic [31:0] d;
        logic        exp_ready, chk_spo;
        logic [31:0] exp_spo;
    } vec_t;

`ifdef PCPU_CLINT_EXT_IRQ_EN
    localparam logic [31:0] EN_RD = 32'h0500_0000;
`else
    localparam logic [31:0] EN_RD = 32'h0;
`endif

    vec_t tbl [17];

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b1, 1'b0, 3'd2, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF},
            '{1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF},
            '{1'b1, 1'b0, 3'd4, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b1, 1'b0, 3'd5, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b1, 1'b0, 3'd6, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b1, 1'b0, 3'd7, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0},
            '{1'b0, 1'b1, 3'd7, sw(32'd123), 1'b1, 1'b0, 32'd0},
            '{1'b1, 1'b0, 3'd7, 32'd0, 1'b1, 1'b1, 32'd0},
            '{1'b0, 1'b1, 3'd2, sw(32'h1234_5678), 1'b1, 1'b0, 32'd0},
            '{1'b1, 1'b0, 3'd2, 32'd0, 1'b1, 1'b1, sw(32'h1234_5678)},
            '{1'b1, 1'b1, 3'd3, sw(32'hAABB_CCDD), 1'b1, 1'b0, 32'd0},
            '{1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 1'b1, sw(32'hAABB_CCDD)},
            '{1'b0, 1'b1, 3'd4, sw(32'd5), 1'b1, 1'b0, 32'd0},
            '{1'b1, 1'b0, 3'd4, 32'd0, 1'b1, 1'b1, EN_RD}
        };
        @(negedge clk);
        do_reset();
        chk("rst_ready", ready, 0);
        chk("rst_spo", spo, 0);
        chk("rst_eip", eip, 0);
        chk("rst_ist", eip_istimer, 0);
        foreach (tbl[i]) begin
            bus(tbl[i].r, tbl[i].w, tbl[i].idx, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_ready);
            if (tbl[i].chk_spo) chk($sformatf("tbl%0d_spo", i), spo, tbl[i].exp_spo);
        end
        rst = 1'b1; rd = 1'b1; a = '0;
        @(negedge clk);
        rd = 1'b0;
        chk("rst_no_ready", ready, 0);

        // compare latency
        do_reset();
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd10);
        for (int k = 0; k < 14; k++) begin
            chk("cmp_eip", eip, cyc >= 11);
            chk("cmp_ist", eip_istimer, cyc >= 11);
            @(negedge clk);
        end
        wr(3'd2, 32'd1000);
        chk("cmp_eip_hold", eip, 1);
        @(negedge clk);
        chk("cmp_eip_fall", eip, 0);

        // 64-bit carry and shadow
        wr(3'd1, 32'd1);
        wr(3'd0, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        rd_chk("wrap_lo", 3'd0, 32'd0);
        wr(3'd1, 32'd7);
        rd_chk("wrap_shadow", 3'd1, 32'd2);
        rd_chk("wrap_lo_after", 3'd0, 32'd2);

`ifdef PCPU_CLINT_EXT_IRQ_EN
        do_reset();
        wr(3'd4, 32'b0101);
        irq_in = 4'b0100;
        @(negedge clk);
        irq_in = '0;
        chk("ext_eip", eip, 1);
        chk("ext_ist", eip_istimer, 0);
        rd_chk("ext_pending", 3'd5, 32'b0100);
        rd_chk("ext_claim", 3'd6, 32'd3);
        eip_reply = 1'b1;
        @(negedge clk);
        eip_reply = 1'b0;
        chk("ext_reply_eip", eip, 0);
        rd_chk("ext_reply_pending", 3'd5, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd0);
        irq_in = 4'b0001;
        @(negedge clk);
        irq_in = '0;
        chk("both_ist", eip_istimer, 1);
        chk("both_eip", eip, 1);
        eip_reply = 1'b1;
        @(negedge clk);
        eip_reply = 1'b0;
        rd_chk("both_pending", 3'd5, 32'd1);
        chk("both_ist_kept", eip_istimer, 1);
        wr(3'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("raise_ist", eip_istimer, 0);
        chk("raise_eip", eip, 1);
        rd_chk("raise_claim", 3'd6, 32'd1);
        irq_in = 4'b0010;
        wr(3'd5, 32'd3);
        irq_in = '0;
        rd_chk("w1c_vs_set", 3'd5, 32'd2);
`else
        do_reset();
        wr(3'd4, 32'hF);
        irq_in = '1;
        @(negedge clk);
        irq_in = '0;
        chk("noext_eip", eip, 0);
        rd_chk("noext_enable", 3'd4, 32'd0);
        rd_chk("noext_pending", 3'd5, 32'd0);
        rd_chk("noext_claim", 3'd6, 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int op;
            op = int'($urandom_range(0, 3));
            rd = (op == 1) || (op == 3);
            we = op >= 2;
            a = $urandom;
            d = sw(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300));
            irq_in = NEXT'($urandom);
            eip_reply = $urandom_range(0, 3) == 0;
            model_step();
            @(negedge clk);
            rd = 1'b0; we = 1'b0; eip_reply = 1'b0;
            chk("rnd_ready", ready, e_ready);
            if (e_rd) chk("rnd_spo", spo, e_spo);
            chk("rnd_eip", eip, e_eip);
            chk("rnd_ist", eip_istimer, e_ist);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pcpu_clint.md
# pcpu_clint

Memory-mapped machine timer and interrupt source controller. It is the bus responder and interrupt source that pairs with the pCPU multicycle core. It answers single-cycle rd/we pulses on the core's word bus with a fixed one-cycle `ready` response. It drives the core's `eip`/`eip_istimer` lines and consumes `eip_reply`. It sits behind the system address decoder, which gates `rd`/`we` so that they are only asserted for this block's address window.

## Interface
Parameters:
- PRESCALE, 1: clk cycles per mtime increment (≥1).
- NEXT, 4: number of external interrupt lines (1..31).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- a  in  32  byte address; only a[4:2] decoded.
- d  in  32  write data, bus byte order.
- we  in  1  write strobe, one-cycle pulse.
- rd  in  1  read strobe, one-cycle pulse.
- spo  out  32  read data, bus byte order; valid only while ready=1.
- ready  out  1  response strobe.
- irq_in  in  NEXT  external interrupt lines, rising-edge sensitive.
- eip  out  1  interrupt request to core.
- eip_istimer  out  1  current request is the timer.
- eip_reply  in  1  core accepted the interrupt, one-cycle pulse.

## Operation
- Byte order: bus word W carries CPU value V = {W[7:0],W[15:8],W[23:16],W[31:24]}. Swap on both d and spo. All registers hold CPU values.
- Register map, word index a[4:2]:
  - 0 mtime_lo RW.
  - 1 mtime_hi. R returns the shadow. W writes mtime[63:32] directly.
  - 2 mtimecmp_lo RW.
  - 3 mtimecmp_hi RW.
  - 4 irq_enable RW, bits [NEXT-1:0].
  - 5 irq_pending. R returns the pending bits. W1C.
  - 6 claim RO: (lowest index i with pending&enable set)+1, or 0 if none.
  - 7 reads 0, writes ignored.
- Shadow: a read of mtime_lo latches mtime[63:32] into the shadow on the same edge.
- Only full-word writes exist; the core does read-modify-write for SB/SH.
- If we and rd are both set, the access is treated as a write and ready is still one cycle.
- mtime: 64-bit, increments once every PRESCALE cycles, wraps 2^64-1→0.
  - A write to either half wins over an increment in the same cycle and clears the prescaler count.
- timer_pend: a register loaded every cycle with (mtime >= mtimecmp), unsigned 64-bit compare. It is level-based; software clears it by raising mtimecmp. eip_reply has no effect on it.
- External lines: irq_prev registers irq_in. A bit becomes pending when irq_in & ~irq_prev.
  - Clear sources: W1C write, or eip_reply while eip_istimer=0, which clears the bit currently reported by claim.
  - Set wins over any same-cycle clear.
- eip = timer_pend | (|(pending & enable)).
- eip_istimer = timer_pend; the timer has priority over external sources.

## Timing
- Reset values:
  - ready=0, spo=0, eip=0, eip_istimer=0.
  - mtime=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, enable=0, pending=0, irq_prev=0, prescaler=0.
- Request sampled at edge N (rd or we high) → ready=1 and spo valid for exactly the cycle after edge N. ready is 0 at all other times.
  - ready must never be high in a request cycle without a request. The core samples ready combinationally in its fetch cycle.
- A new request may arrive in the ready cycle; it is answered the next cycle (back-to-back throughput 1/cycle).
- Read data reflects register state before the request edge. Writes take effect at the request edge.
- Compare latency: eip rises one cycle after mtime ≥ mtimecmp first holds, and falls one cycle after a mtimecmp write removes the condition.
- External edge → pending at the next edge → eip high in that same cycle.
- rst mid-transaction: no ready is issued for a request sampled on a reset edge.

## Configuration
- PCPU_CLINT_EXT_IRQ_EN defined: external lines and registers 4–6 are present as specified.
- PCPU_CLINT_EXT_IRQ_EN undefined:
  - irq_in is ignored.
  - Registers 4–6 read 0 and ignore writes.
  - eip = eip_istimer = timer_pend.
  - eip_reply is ignored.
  - Bus timing is unchanged.

## Test plan
- Reset, then read each index 0–7 → ready exactly one cycle after each rd. spo swapped values: 0,0,FFFFFFFF,FFFFFFFF,0,0,0,0.
- Write mtimecmp_hi=0 then mtimecmp_lo=10 (PRESCALE=1) → eip=1 and eip_istimer=1 one cycle after mtime==10. Write mtimecmp_lo=1000 → eip=0 one cycle later.
- Write mtime_hi=1, mtime_lo=FFFFFFFE; read lo then hi → wrap carry is visible. hi read returns the value latched at the lo read even after mtime_hi changes.
- enable=0b0101; pulse irq_in[2] → pending=0b0100, claim=3, eip=1, eip_istimer=0. eip_reply → pending=0, eip=0.
- Timer pending and irq_in[0] pending together → eip_istimer=1. eip_reply leaves both pending. After mtimecmp is raised → eip_istimer=0 and claim=1.
- Back-to-back rd on consecutive cycles → two consecutive ready cycles with the correct data each. irq edge coinciding with a W1C of the same bit → bit remains set.
